// File: rtl/inverter_display_scan.sv
// Multi-digit switch inverter: synchronised, inverted switches scanned onto a shared 7-seg bus.
// Optional macro SW_DEBOUNCE_EN adds a per-bit stability filter after the synchroniser.
module inverter_display_scan #(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] sw,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [NUM_DIGITS-1:0] inv_out
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [NUM_DIGITS-1:0] s1;
    logic [NUM_DIGITS-1:0] s2;
    logic [NUM_DIGITS-1:0] st;
    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic                  active;
    logic                  tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [NUM_DIGITS];

    // A bit is accepted only after s2 disagrees with st for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    st[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign st = s2;
`endif

    assign tick = (pre == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // The first tick only arms the scan so digit 0 gets a full slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            active <= 1'b0;
        end else if (tick) begin
            if (!active) begin
                active <= 1'b1;
            end else if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_out <= '1;
            seg     <= SEG_BLANK;
            an      <= '1;
        end else begin
            inv_out <= ~st;
            if (!active) begin
                seg <= SEG_BLANK;
                an  <= '1;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx);
                seg <= inv_out[idx] ? SEG_ONE : SEG_ZERO;
            end
        end
    end

endmodule

// File: tb/tb_inverter_display_scan.sv
// Bench for inverter_display_scan: vector table, hand sequences and a
// randomised run against an arithmetic scan model (two parameter sets).
module tb_inverter_display_scan;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] sw_a = '0;
    logic [2:0] sw_b = '0;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [3:0] an_a;
    logic [2:0] an_b;
    logic [3:0] inv_a;
    logic [2:0] inv_b;

    int vectors = 0;
    int errs    = 0;
    int ka      = 0;
    int kb      = 0;

    logic [3:0] hist [0:1023];

    always #5 clk = ~clk;

    inverter_display_scan #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)
    ) dut_a (
        .clk(clk), .reset(rst_a), .sw(sw_a),
        .seg(seg_a), .an(an_a), .inv_out(inv_a)
    );

    inverter_display_scan #(
        .NUM_DIGITS(3), .REFRESH_DIV(1), .DEBOUNCE_CYCLES(8)
    ) dut_b (
        .clk(clk), .reset(rst_b), .sw(sw_b),
        .seg(seg_b), .an(an_b), .inv_out(inv_b)
    );

    typedef struct {
        int         cyc;
        logic [3:0] sw;
        logic [6:0] seg;
        logic [3:0] an;
        logic [3:0] inv;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: inv_out after edge k reflects sw sampled at edge k-2.
    function automatic logic [3:0] inv_exp(input int k, input int n);
        logic [3:0] m;
        m = 4'((1 << n) - 1);
        if (k < 3) return m;
        return ~hist[k-2] & m;
    endfunction

    function automatic int idx_exp(input int k, input int n, input int r);
        return ((k - r - 1) / r) % n;
    endfunction

    function automatic logic [3:0] an_exp(input int k, input int n, input int r);
        logic [3:0] m;
        m = 4'((1 << n) - 1);
        if (k <= r) return m;
        return ~(4'(1) << idx_exp(k, n, r)) & m;
    endfunction

    function automatic logic [6:0] seg_exp(input int k, input int n, input int r);
        logic [3:0] iv;
        if (k <= r) return 7'b1111111;
        iv = inv_exp(k - 1, n);
        return iv[idx_exp(k, n, r)] ? 7'b1111001 : 7'b1000000;
    endfunction

    task automatic tick_a(input logic [3:0] nsw);
        sw_a = nsw;
        hist[ka+1] = nsw;
        @(posedge clk);
        ka++;
        #1;
    endtask

    task automatic tick_b(input logic [2:0] nsw);
        sw_b = nsw;
        hist[kb+1] = {1'b0, nsw};
        @(posedge clk);
        kb++;
        #1;
    endtask

    task automatic model_a();
        chk("a_seg", {1'b0, seg_a}, {1'b0, seg_exp(ka, 4, 4)});
        chk("a_an", {4'b0, an_a}, {4'b0, an_exp(ka, 4, 4)});
        chk("a_inv", {4'b0, inv_a}, {4'b0, inv_exp(ka, 4)});
    endtask

    task automatic model_b();
        logic [3:0] ea;
        logic [3:0] ei;
        ea = an_exp(kb, 3, 1);
        ei = inv_exp(kb, 3);
        chk("b_seg", {1'b0, seg_b}, {1'b0, seg_exp(kb, 3, 1)});
        chk("b_an", {5'b0, an_b}, {5'b0, ea[2:0]});
        chk("b_inv", {5'b0, inv_b}, {5'b0, ei[2:0]});
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("a_rst_seg", {1'b0, seg_a}, 8'h7f);
        chk("a_rst_an", {4'b0, an_a}, 8'h0f);
        chk("a_rst_inv", {4'b0, inv_a}, 8'h0f);
        @(negedge clk);
        rst_a = 1'b0;
        ka = 0;
    endtask

    initial begin
        logic [3:0] cur;
        logic [2:0] anb [5];
        int e0;

        tbl[0] = '{2, 4'b0101, 7'b1111111, 4'b1111, 4'b1111};
        tbl[1] = '{2, 4'b0101, 7'b1111111, 4'b1111, 4'b1010};
        tbl[2] = '{4, 4'b0101, 7'b1000000, 4'b1110, 4'b1010};
        tbl[3] = '{4, 4'b0101, 7'b1111001, 4'b1101, 4'b1010};
        tbl[4] = '{4, 4'b0101, 7'b1000000, 4'b1011, 4'b1010};
        tbl[5] = '{4, 4'b0101, 7'b1111001, 4'b0111, 4'b1010};
        tbl[6] = '{1, 4'b0101, 7'b1000000, 4'b1110, 4'b1010};

        anb[0] = 3'b111;
        anb[1] = 3'b110;
        anb[2] = 3'b101;
        anb[3] = 3'b011;
        anb[4] = 3'b110;

        repeat (2) @(posedge clk);

`ifdef SW_DEBOUNCE_EN
        reset_a();
        repeat (6) tick_a(4'b0000);
        chk("db_settle", {7'b0, inv_a[1]}, 8'd1);
        repeat (5) tick_a(4'b0010);
        for (int i = 0; i < 20; i++) begin
            tick_a(4'b0000);
            chk("db_glitch", {7'b0, inv_a[1]}, 8'd1);
        end
        e0 = ka;
        for (int i = 0; i < 12; i++) begin
            tick_a(4'b0010);
            chk("db_hold", {7'b0, inv_a[1]},
                (ka <= e0 + 10) ? 8'd1 : 8'd0);
        end
`else
        // Table: sw=0101 held from reset through one full frame and the wrap
        sw_a = 4'b0101;
        reset_a();
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < tbl[r].cyc; c++) begin
                tick_a(tbl[r].sw);
                chk($sformatf("tbl%0d_seg", r), {1'b0, seg_a}, {1'b0, tbl[r].seg});
                chk($sformatf("tbl%0d_an", r), {4'b0, an_a}, {4'b0, tbl[r].an});
                chk($sformatf("tbl%0d_inv", r), {4'b0, inv_a}, {4'b0, tbl[r].inv});
            end
        end

        // sw[0] rises while digit 0 is lit
        reset_a();
        repeat (4) tick_a(4'b0000);
        tick_a(4'b0001);
        tick_a(4'b0001);
        chk("tog_inv_e6", {7'b0, inv_a[0]}, 8'd1);
        tick_a(4'b0001);
        chk("tog_inv_e7", {7'b0, inv_a[0]}, 8'd0);
        chk("tog_seg_e7", {1'b0, seg_a}, {1'b0, 7'b1111001});
        tick_a(4'b0001);
        chk("tog_seg_e8", {1'b0, seg_a}, {1'b0, 7'b1000000});
        chk("tog_an_e8", {4'b0, an_a}, 8'b0000_1110);

        // Asynchronous reset while digit 2 is lit
        reset_a();
        repeat (14) tick_a(4'b0000);
        chk("mid_an_pre", {4'b0, an_a}, 8'b0000_1011);
        #2;
        rst_a = 1'b1;
        #1;
        chk("mid_rst_seg", {1'b0, seg_a}, 8'h7f);
        chk("mid_rst_an", {4'b0, an_a}, 8'h0f);
        chk("mid_rst_inv", {4'b0, inv_a}, 8'h0f);
        @(negedge clk);
        rst_a = 1'b0;
        ka = 0;
        repeat (4) tick_a(4'b0000);
        chk("mid_blank_e4", {4'b0, an_a}, 8'h0f);
        tick_a(4'b0000);
        chk("mid_lit_e5", {4'b0, an_a}, 8'b0000_1110);
        chk("mid_seg_e5", {1'b0, seg_a}, {1'b0, 7'b1111001});

        // Randomised run on the 4-digit instance
        reset_a();
        cur = 4'($urandom);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
            tick_a(cur);
            model_a();
        end
        rst_a = 1'b1;

        // 3-digit instance, one-cycle slots
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("b_rst_an", {5'b0, an_b}, 8'h07);
        @(negedge clk);
        rst_b = 1'b0;
        kb = 0;
        for (int i = 0; i < 5; i++) begin
            tick_b(3'b000);
            chk($sformatf("b_seq%0d", i), {5'b0, an_b}, {5'b0, anb[i]});
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        kb = 0;
        for (int i = 0; i < 60; i++) begin
            tick_b(3'($urandom));
            model_b();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/inverter_display_scan.md
Name: inverter_display_scan

Overview:
- Parametrised multi-channel successor to the single-switch inverter display.
- Each of NUM_DIGITS switches is synchronised, inverted and shown as "0"/"1" on its own seven-segment digit.
- Digits are time-multiplexed through the shared active-low seg/an bus; the block sits between board switches and the display pins.
- The inverted values are also exported for downstream logic.

Parameters:
- NUM_DIGITS, 4, number of switch/digit channels; legal range >= 1.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range >= 1.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a switch change; used only with SW_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  NUM_DIGITS  raw switch inputs, asynchronous to clk.
- seg  output  7  active-low segments, seg[6]=g … seg[0]=a; registered.
- an  output  NUM_DIGITS  active-low digit enables, an[i] drives digit i; registered.
- inv_out  output  NUM_DIGITS  registered inverted switch values, inv_out[i] = ~sw[i] after synchronisation.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - seg = 7'b1111111 (blank).
  - an = all ones (all digits off).
  - inv_out = all ones.
  - Synchroniser flops = 0.
  - Prescaler = 0, index = 0, active = 0.
- Reset asserted mid-scan returns to these values immediately, without waiting for a clock edge.
- Synchroniser:
  - Two flops per bit: s1 <= sw, s2 <= s1.
  - Stable value st = s2 (debounce option off).
- Inversion: inv_out <= ~st every cycle.
- Prescaler:
  - Width max(1, clog2(REFRESH_DIV)).
  - Counts 0 … REFRESH_DIV-1.
  - tick = 1 in the cycle it equals REFRESH_DIV-1, then it wraps to 0.
  - REFRESH_DIV = 1 gives tick every cycle.
- Index:
  - Width max(1, clog2(NUM_DIGITS)).
  - On tick: if active = 0, set active = 1 and hold index = 0; else index advances by 1.
  - Index wraps NUM_DIGITS-1 -> 0; it never takes values >= NUM_DIGITS.
- Outputs, registered every cycle:
  - When active = 0: seg = blank, an = all ones.
  - When active = 1: an = ~(1 << index), exactly one bit low.
  - When active = 1: seg = 7'b1111001 ("1") if inv_out[index] = 1, else 7'b1000000 ("0").
- Latency:
  - A sw[i] change reaches inv_out[i] at the 3rd rising edge.
  - It reaches seg at the 4th edge, provided digit i is selected.
  - A change during another digit's slot appears at the start of digit i's next slot.
- First slot: digit 0 is lit one cycle after the first tick, i.e. REFRESH_DIV+1 edges after reset release.
- Full scan: NUM_DIGITS*REFRESH_DIV cycles per frame. an and seg change together on the same edge, so there is no cross-digit ghosting.
- NUM_DIGITS = 1: an stays 1'b0 once active; index never changes.

Optional Feature:
- Macro: SW_DEBOUNCE_EN.
- Defined:
  - Per-bit counter, width clog2(DEBOUNCE_CYCLES+1).
  - While s2[i] != st[i] the counter increments.
  - On reaching DEBOUNCE_CYCLES-1, st[i] <= s2[i] and the counter clears.
  - Any cycle with s2[i] == st[i] clears the counter.
  - st resets to 0.
  - Added latency: DEBOUNCE_CYCLES cycles after the synchroniser.
- Undefined: st = s2 directly; no counters are instantiated.

Test Plan:
- Reset release, NUM_DIGITS=4, REFRESH_DIV=4, sw=4'b0000 -> seg=7'b1111111 and an=4'b1111 for the first 4 edges; then an=4'b1110 with seg=7'b1111001; inv_out=4'b1111 throughout.
- sw=4'b0101 held, full frame -> an sequence 1110, 1101, 1011, 0111, each for 4 cycles; seg "0","1","0","1" (7'b1000000, 7'b1111001, 7'b1000000, 7'b1111001); then wraps to 1110.
- Toggle sw[0] 0->1 while an=4'b1110 -> inv_out[0] falls at the 3rd edge; seg becomes 7'b1000000 at the 4th edge if still in slot 0.
- Assert reset mid-slot with index=2 -> seg=7'b1111111, an=4'b1111, inv_out=4'b1111 immediately without a clock edge; after release, the scan restarts at digit 0 after REFRESH_DIV+1 edges.
- REFRESH_DIV=1, NUM_DIGITS=3 -> an cycles 110, 101, 011 on consecutive edges; index never reaches 3.
- SW_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle glitch on sw[1] -> inv_out[1] unchanged; 12-cycle hold -> inv_out[1] toggles exactly 8 cycles after s2 settles.
